ifetch_prefetch_queue: RTL
==========================

// Module: ifetch_prefetch_queue
// PURPOSE
//   Parametrised instruction-fetch front end for the pipelined CPU. Replaces the single-word
//   combinational INSTRUCTION input with a request/response port to instruction memory and a DEPTH-entry prefetch queue.
//   Absorbs variable memory latency and decode backpressure, and discards wrong-path fetches on a branch/jump redirect.
//   Sits between the instruction memory and the stage-1 decoder; stage 2 drives redirect_* when a branch or jump is taken.
// PARAMETERS
//   XLEN      32  address/PC width
//   DEPTH     4   queue entries = max outstanding+buffered fetches; power of 2, >=2
//   RESET_PC  0   fetch address after reset; bits [1:0] must be 0
// PORTS
//   CLK             in   1     clock, all state updates on rising edge
//   rst             in   1     synchronous, active-high reset
//   imem_req_valid  out  1     fetch request valid
//   imem_req_addr   out  XLEN  word-aligned fetch address
//   imem_req_ready  in   1     memory accepts request this cycle
//   imem_rsp_valid  in   1     instruction word returned (in request order, >=1 cycle after accept)
//   imem_rsp_data   in   32    returned instruction word
//   redirect_valid  in   1     taken branch/jump: flush and refetch
//   redirect_pc     in   XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
//   dec_valid       out  1     queue head valid for decoder
//   dec_instr       out  32    head instruction
//   dec_pc          out  XLEN  head instruction address
//   dec_ready       in   1     decoder consumes head this cycle
//   queue_count     out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//   Reset: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, queue_count=0,
//     state=FETCH, outstanding=0, drop_cnt=0. Reset mid-operation discards everything; memory responses
//     arriving in the cycle after reset deassertion are not tracked (the memory is reset on the same rst).
//   Handshakes: request transfers on imem_req_valid & imem_req_ready; pop on dec_valid & dec_ready.
//   Credit rule: imem_req_valid = (state==FETCH) & !redirect_valid & (outstanding + queue_count < DEPTH).
//     The queue therefore never overflows; no response is ever dropped for lack of space.
//   fetch_pc increments by 4 on each accepted request and wraps modulo 2^XLEN.
//   Push: a response in FETCH writes {imem_rsp_data, pc_of_that_request} at the tail; outstanding decrements.
//     The per-entry PC comes from a DEPTH-deep in-flight PC FIFO written on request accept.
//   Latency: a response in cycle N gives dec_valid=1 in cycle N+1 (registered queue, no bypass).
//   Simultaneous push and pop is allowed at any occupancy; queue_count is unchanged.
//   Pointer and count arithmetic: $clog2(DEPTH)-bit pointers wrap naturally; count/outstanding are $clog2(DEPTH+1) bits.
//   States:
//     FETCH: normal operation.
//     DRAIN: waits for stale responses; no requests issued; every response is discarded; drop_cnt decrements.
//   Redirect (cycle N, any state): the queue is flushed (queue_count=0 and dec_valid=0 in N+1), the in-flight PC FIFO
//     is cleared, and fetch_pc=redirect_pc&~3 in N+1. The pop is ignored in N.
//     stale = outstanding - (rsp_valid in N) + (request accepted in N ? 1 : 0). Because imem_req_valid is gated by
//       redirect_valid, no request is accepted in N and that term is 0.
//     If stale==0 -> FETCH in N+1, first request at redirect_pc in N+1. Otherwise -> DRAIN with drop_cnt=stale.
//     A response arriving in N itself is discarded.
//   Redirect during DRAIN: fetch_pc is updated and drop_cnt = drop_cnt - rsp_valid; the state stays DRAIN.
//   DRAIN -> FETCH: in the cycle the last stale response arrives (drop_cnt==1 & rsp_valid). Requests resume the next cycle.
//   imem_req_addr = fetch_pc and is held stable while valid & !ready, unless redirect or reset occurs.
// TESTING
//   1. rst for 2 cycles, then release -> cycle after release: req_valid=1, addr=0x0; dec_valid=0; queue_count=0.
//   2. Fixed 1-cycle memory latency, dec_ready=1 -> dec_pc sequence 0x0,0x4,0x8... back-to-back after fill;
//      dec_instr matches memory image.
//   3. dec_ready=0, DEPTH=4 -> exactly 4 requests accepted (0x0-0xC); req_valid=0 while queue_count=4;
//      one pop -> one new request at 0x10.
//   4. 3-cycle latency, 2 requests outstanding, redirect_pc=0x100 -> state DRAIN, 2 responses discarded,
//      next request addr=0x100, first dec_pc=0x100.
//   5. Redirect in the same cycle as a response and a pop, outstanding=1 -> that response discarded, stale=0,
//      FETCH; request 0x200 (redirect_pc=0x202 -> 0x200) in next cycle.
//   6. Assert rst while in DRAIN with drop_cnt=2 -> all outputs at reset values next cycle; after release,
//      fetch restarts at RESET_PC with no spurious dec_valid.

Source files
------------

// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch front end: issues word fetches under a credit limit, buffers returned
// words with their PCs in a DEPTH-entry queue, and drops wrong-path responses after a redirect.
module ifetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             PW       = $clog2(DEPTH),
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic            CLK,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc,
    input  logic            dec_ready,
    output logic [CW-1:0]   queue_count,
    output logic            dbg_drain,
    output logic [CW-1:0]   dbg_drop_cnt
);
    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   q_wr_q, q_rd_q, ifl_wr_q, ifl_rd_q;
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] ifl_pc    [DEPTH];

    logic credit_ok, accept, rsp_fetch, rsp_drain, push, pop;

    // Handshakes: a request transfers when imem_req_valid && imem_req_ready; the decoder pops when
    // dec_valid && dec_ready. Valid never depends on ready, and a redirect cancels both in its cycle.
    assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
    assign imem_req_valid = !rst && (state_q == FETCH) && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_fetch      = (state_q == FETCH) && imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drain      = (state_q == DRAIN) && imem_rsp_valid && (drop_cnt_q != '0);
    assign push           = rsp_fetch && !redirect_valid;
    assign pop            = dec_valid && dec_ready && !redirect_valid;

    assign dec_valid    = (count_q != '0);
    assign dec_instr    = dec_valid ? instr_mem[q_rd_q] : '0;
    assign dec_pc       = dec_valid ? pc_mem[q_rd_q] : '0;
    assign queue_count  = count_q;
    assign dbg_drain    = (state_q == DRAIN);
    assign dbg_drop_cnt = drop_cnt_q;

    always_ff @(posedge CLK) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // A response landing in the redirect cycle is already wrong-path, so it is not counted as stale.
    always_comb begin
        state_d       = state_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_fetch);
        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    outstanding_d = '0;
                    drop_cnt_d    = outstanding_q - CW'(rsp_fetch);
                    if (drop_cnt_d != '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                outstanding_d = '0;
                if (rsp_drain) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                    if (drop_cnt_q == CW'(1)) state_d = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            q_wr_q        <= '0;
            q_rd_q        <= '0;
            ifl_wr_q      <= '0;
            ifl_rd_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc & ~(XLEN'(3));
                count_q    <= '0;
                q_wr_q     <= '0;
                q_rd_q     <= '0;
                ifl_wr_q   <= '0;
                ifl_rd_q   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc_q <= fetch_pc_q + XLEN'(4);
                    ifl_wr_q   <= ifl_wr_q + 1'b1;
                end
                if (push) begin
                    q_wr_q   <= q_wr_q + 1'b1;
                    ifl_rd_q <= ifl_rd_q + 1'b1;
                end
                if (pop) q_rd_q <= q_rd_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays carry no reset; occupancy and pointers decide what is visible.
    always_ff @(posedge CLK) begin
        if (accept) ifl_pc[ifl_wr_q] <= fetch_pc_q;
        if (push) begin
            instr_mem[q_wr_q] <= imem_rsp_data;
            pc_mem[q_wr_q]    <= ifl_pc[ifl_rd_q];
        end
    end
endmodule
